mips_imem_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. It accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory through a write port. The loader holds the core in reset until the full program is written, then releases it. It sits between the board-level byte source (UART receiver or bench) and the instruction memory / core reset input.

---
 rtl/mips_imem_loader_if.sv | 27 ++
 rtl/mips_imem_loader.sv | 171 +++++++++++++++++
 tb/tb_mips_imem_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_imem_loader_if.sv
// Byte-stream handshake between a program source (UART receiver or bench) and the loader.
//
// Signals:
//   byte_valid  source -> loader  byte_data holds a valid program byte
//   byte_data   source -> loader  program byte, most-significant byte of each word first
//   byte_ready  loader -> source  loader takes the offered byte on this rising edge
//
// Modports:
//   master  the byte source
//   slave   the loader
interface mips_imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/mips_imem_loader.sv
// Boot-time program loader for the single-cycle MIPS core.
//
// Receives a program as a byte stream, assembles big-endian 32-bit instruction words and writes
// each one into instruction memory. The core is held in reset until the whole program has been
// written, then released.
//
// Parameters:
//   ADDR_WIDTH    instruction-memory word-address width (depth 2**ADDR_WIDTH words)
//
// Ports:
//   clk_i         system clock, all state updates on the rising edge
//   rst_i         synchronous, active-high reset
//   start_i       single-cycle load request, honoured only in IDLE and DONE
//   word_count_i  number of words to load, sampled with an accepted start
//   bus           byte-stream handshake (slave side)
//   imem_we_o     instruction-memory write enable, one cycle per word
//   imem_addr_o   word address of the write
//   imem_wdata_o  assembled instruction word
//   cpu_reset_o   active-high reset to the MIPS core
//   busy_o        load in progress
//   done_o        program loaded, core running
//   checksum_o    sum modulo 2**32 of all words written in the current load
module mips_imem_loader #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  mips_imem_loader_if.slave     bus,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           checksum_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MaxCount = (ADDR_WIDTH + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           cksum_q, cksum_d;
  logic [1:0]            bcnt_q, bcnt_d;

  logic                  byte_ready;
  logic                  byte_fire;
  logic                  start_accept;
  logic                  last_word;
  logic [ADDR_WIDTH:0]   count_sat;

  assign byte_fire    = bus.byte_valid && byte_ready;
  assign start_accept = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign count_sat    = (word_count_i > MaxCount) ? MaxCount : word_count_i;
  // count_q is never zero while in WRITE, so count_q - 1 is the last word address.
  assign last_word    = ({1'b0, addr_q} == (count_q - (ADDR_WIDTH + 1)'(1)));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = (word_count_i == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (byte_fire && (bcnt_q == 2'd3)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = last_word ? StDone : StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    byte_ready  = 1'b0;
    imem_we_o   = 1'b0;
    cpu_reset_o = 1'b1;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        byte_ready = 1'b1;
        busy_o     = 1'b1;
      end
      StWrite: begin
        imem_we_o = 1'b1;
        busy_o    = 1'b1;
      end
      StDone: begin
        cpu_reset_o = 1'b0;
        done_o      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cksum_d = cksum_q;
    bcnt_d  = bcnt_q;
    if (start_accept) begin
      count_d = count_sat;
      addr_d  = '0;
      bcnt_d  = '0;
      cksum_d = '0;
    end
    if ((state_q == StLoad) && byte_fire) begin
      wdata_d = {wdata_q[23:0], bus.byte_data};
      bcnt_d  = bcnt_q + 2'd1;
    end
    if (state_q == StWrite) begin
      cksum_d = cksum_q + wdata_q;
      // Address stays on the last written word once the load completes.
      if (!last_word) begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cksum_q <= '0;
      bcnt_q  <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cksum_q <= cksum_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign checksum_o     = cksum_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader: drives a byte stream, logs every memory write and
// compares outputs against hand-computed values.
module tb_mips_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  word_count;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  mips_imem_loader_if bus ();

  mips_imem_loader #(
    .ADDR_WIDTH(6)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .word_count_i(word_count),
    .bus         (bus),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .cpu_reset_o (cpu_reset),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Write log
  logic [5:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_cnt = 0;
  int          we_ready_bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] <= imem_addr;
        wr_data[wr_cnt] <= imem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
      if (bus.byte_ready) we_ready_bad <= we_ready_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns one negedge after the sampling edge.
  task automatic do_start(input logic [6:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      acc = bus.byte_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  logic [7:0] prog [8];
  int base;
  int t0;
  logic [31:0] sum;

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h20; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h07;
    rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);

    // Two-word back-to-back load
    base = wr_cnt;
    t0 = cyc;
    do_start(7'd2);
    check("b2b_ready_first", 32'(bus.byte_ready), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    wait_done();
    check("b2b_done_latency", 32'(cyc - t0), 32'd11);
    check("b2b_cpu_reset", 32'(cpu_reset), 32'd0);
    check("b2b_wr_count", 32'(wr_cnt - base), 32'd2);
    check("b2b_addr0", 32'(wr_addr[base]), 32'd0);
    check("b2b_data0", wr_data[base], 32'h20080005);
    check("b2b_addr1", 32'(wr_addr[base+1]), 32'd1);
    check("b2b_data1", wr_data[base+1], 32'h20090007);
    check("b2b_checksum", checksum, 32'h4011000C);
    check("b2b_final_addr", 32'(imem_addr), 32'd1);

    // Gapped stream, started from DONE
    base = wr_cnt;
    do_start(7'd2);
    check("gap_cpu_reset_back", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], int'($urandom_range(0, 3)));
    wait_done();
    check("gap_wr_count", 32'(wr_cnt - base), 32'd2);
    check("gap_data0", wr_data[base], 32'h20080005);
    check("gap_data1", wr_data[base+1], 32'h20090007);
    check("gap_addr1", 32'(wr_addr[base+1]), 32'd1);
    check("gap_checksum", checksum, 32'h4011000C);
    check("write_ready_overlap", 32'(we_ready_bad), 32'd0);

    // Zero-length load from IDLE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("zero_pre_checksum", checksum, 32'd0);
    base = wr_cnt;
    do_start(7'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_write", 32'(wr_cnt - base), 32'd0);
    check("zero_checksum", checksum, 32'd0);

    // Reset mid-load, then a one-word load
    base = wr_cnt;
    do_start(7'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_ready", 32'(bus.byte_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_write", 32'(wr_cnt - base), 32'd0);
    check("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);
    do_start(7'd1);
    send_byte(8'h8C, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    wait_done();
    check("midrst_wr_count", 32'(wr_cnt - base), 32'd1);
    check("midrst_addr", 32'(wr_addr[base]), 32'd0);
    check("midrst_data", wr_data[base], 32'h8C100004);
    check("midrst_checksum", checksum, 32'h8C100004);

    // Reload from DONE with a start pulse ignored during LOAD
    base = wr_cnt;
    check("reload_pre_cpu_reset", 32'(cpu_reset), 32'd0);
    do_start(7'd1);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_done_low", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    do_start(7'd3);
    check("ignored_start_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done();
    check("reload_wr_count", 32'(wr_cnt - base), 32'd1);
    check("reload_addr", 32'(wr_addr[base]), 32'd0);
    check("reload_data", wr_data[base], 32'd0);
    check("reload_checksum", checksum, 32'd0);

    // Count saturation: 100 requested, 64 words written (word i = i)
    base = wr_cnt;
    sum = 32'd0;
    do_start(7'd100);
    for (int w = 0; w < 64; w++) begin
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'(w), 0);
      sum = sum + 32'(w);
    end
    wait_done();
    check("sat_wr_count", 32'(wr_cnt - base), 32'd64);
    check("sat_first_addr", 32'(wr_addr[base]), 32'd0);
    check("sat_last_addr", 32'(wr_addr[base+63]), 32'd63);
    check("sat_last_data", wr_data[base+63], 32'd63);
    check("sat_checksum", checksum, 32'h000007E0);
    check("sat_checksum_model", checksum, sum);
    check("sat_final_addr", 32'(imem_addr), 32'd63);
    check("sat_ready_in_done", 32'(bus.byte_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
